// File: rtl/video_char_gen_if.sv
// Bus between the text-mode video generator and its video RAM, font ROM and output pads.
// The master side is the generator; the slave side is the memories/pads.
interface video_char_gen_if;
    logic [9:0]  vid_addr;
    logic [7:0]  vid_data;
    logic [10:0] font_addr;
    logic [7:0]  font_data;
    logic        luma;
    logic        sync;
    logic        frame_pulse;

    modport master (
        output vid_addr,
        output font_addr,
        output luma,
        output sync,
        output frame_pulse,
        input  vid_data,
        input  font_data
    );

    modport slave (
        input  vid_addr,
        input  font_addr,
        input  luma,
        input  sync,
        input  frame_pulse,
        output vid_data,
        output font_data
    );
endinterface

// File: rtl/video_char_gen.sv
// Text-mode composite video generator: raster counters, H/V sync, a char/glyph fetch
// pipeline against registered-read video RAM and font ROM, and a 2 clk/px luma shifter.
module video_char_gen #(
    parameter int H_TOTAL     = 1016,
    parameter int HSYNC_LEN   = 75,
    parameter int H_ACT_START = 160,
    parameter int V_TOTAL     = 262,
    parameter int VSYNC_LINES = 3,
    parameter int V_ACT_START = 40,
    parameter int COLS        = 32,
    parameter int ROWS        = 25
) (
    input  logic              clk,
    input  logic              reset,
    video_char_gen_if.master  vbus
);

    localparam int HCNT_W  = $clog2(H_TOTAL + 1);
    localparam int VCNT_W  = $clog2(V_TOTAL + 1);
    localparam int ACT_PIX = COLS * 16;

    localparam logic [HCNT_W-1:0] H_LAST_C        = HCNT_W'(H_TOTAL - 1);
    localparam logic [HCNT_W-1:0] H_SYNC_END_C    = HCNT_W'(HSYNC_LEN);
    localparam logic [HCNT_W-1:0] H_VSYNC_HI_C    = HCNT_W'(H_TOTAL - HSYNC_LEN);
    localparam logic [HCNT_W-1:0] H_ACT_FIRST_C   = HCNT_W'(H_ACT_START);
    localparam logic [HCNT_W-1:0] H_ACT_END_C     = HCNT_W'(H_ACT_START + ACT_PIX);
    localparam logic [HCNT_W-1:0] H_FETCH_FIRST_C = HCNT_W'(H_ACT_START - 5);
    localparam logic [HCNT_W-1:0] H_FETCH_END_C   = HCNT_W'(H_ACT_START - 5 + ACT_PIX);

    localparam logic [VCNT_W-1:0] V_LAST_C        = VCNT_W'(V_TOTAL - 1);
    localparam logic [VCNT_W-1:0] V_VSYNC_END_C   = VCNT_W'(VSYNC_LINES);
    localparam logic [VCNT_W-1:0] V_ACT_FIRST_C   = VCNT_W'(V_ACT_START);
    localparam logic [VCNT_W-1:0] V_ACT_END_C     = VCNT_W'(V_ACT_START + ROWS * 8);

    localparam logic [9:0]        ROW_STEP_C      = 10'(COLS);

    // Registered state
    logic [HCNT_W-1:0] hcnt_reg, hcnt_next;
    logic [VCNT_W-1:0] vcnt_reg, vcnt_next;
    logic [9:0]        row_base_reg, row_base_next;
    logic [9:0]        vid_addr_reg, vid_addr_next;
    logic [10:0]       font_addr_reg, font_addr_next;
    logic [7:0]        shift_reg, shift_next;
    logic              luma_reg, luma_next;
    logic              sync_reg, sync_next;
    logic              frame_pulse_reg, frame_pulse_next;

    // Decode of the current raster position
    logic              line_active;
    logic [2:0]        glyph_row;
    logic              in_fetch;
    logic [HCNT_W-1:0] fetch_rel;
    logic [3:0]        fetch_phase;
    logic [9:0]        char_idx;
    logic              in_pix;
    logic              shift_load;
    logic              shift_step;
    logic [7:0]        shift_in;

    assign line_active = (vcnt_reg >= V_ACT_FIRST_C) && (vcnt_reg < V_ACT_END_C);
    assign glyph_row   = vcnt_reg[2:0] - V_ACT_FIRST_C[2:0];

    // Fetch slot k starts at A-5 (A = first pixel cycle of char k); phases 0/2/4
    // launch the RAM address, the ROM address and the shifter load respectively.
    assign in_fetch    = line_active && (hcnt_reg >= H_FETCH_FIRST_C) && (hcnt_reg < H_FETCH_END_C);
    assign fetch_rel   = hcnt_reg - H_FETCH_FIRST_C;
    assign fetch_phase = fetch_rel[3:0];
    assign char_idx    = 10'(fetch_rel >> 4);

    assign in_pix      = line_active && (hcnt_reg >= H_ACT_FIRST_C) && (hcnt_reg < H_ACT_END_C);
    assign shift_load  = in_fetch && (fetch_phase == 4'd4);
    assign shift_step  = in_pix && (hcnt_reg[0] ^ H_ACT_FIRST_C[0]);

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_shift_in
            if (gi == 0) begin : g_lsb
                assign shift_in[gi] = 1'b0;
            end else begin : g_upper
                assign shift_in[gi] = shift_reg[gi-1];
            end
        end
    endgenerate

    // Raster counters, frame pulse and character-row base
    always_comb begin
        hcnt_next        = hcnt_reg + 1'b1;
        vcnt_next        = vcnt_reg;
        frame_pulse_next = 1'b0;
        row_base_next    = row_base_reg;
        if (hcnt_reg == H_LAST_C) begin
            hcnt_next = '0;
            if (vcnt_reg == V_LAST_C) begin
                vcnt_next        = '0;
                frame_pulse_next = 1'b1;
            end else begin
                vcnt_next = vcnt_reg + 1'b1;
            end
            // Base advances on the first line of each new char row; no multiplier needed.
            if (vcnt_next == V_ACT_FIRST_C) begin
                row_base_next = '0;
            end else if ((vcnt_next > V_ACT_FIRST_C) && (vcnt_next < V_ACT_END_C) &&
                         ((vcnt_next[2:0] - V_ACT_FIRST_C[2:0]) == 3'd0)) begin
                row_base_next = row_base_reg + ROW_STEP_C;
            end
        end
    end

    // Fetch pipeline, shifter and pad outputs
    always_comb begin
        vid_addr_next  = vid_addr_reg;
        font_addr_next = font_addr_reg;
        if (in_fetch && (fetch_phase == 4'd0)) begin
            vid_addr_next = row_base_reg + char_idx;
        end
        if (in_fetch && (fetch_phase == 4'd2)) begin
            font_addr_next = {vbus.vid_data, glyph_row};
        end

        if (shift_load) begin
            shift_next = vbus.font_data;
        end else if (shift_step) begin
            shift_next = shift_in;
        end else begin
            shift_next = shift_reg;
        end

        luma_next = in_pix ? shift_reg[7] : 1'b0;

        // Vertical-sync lines carry inverted (broad) pulses.
        if (vcnt_reg < V_VSYNC_END_C) begin
            sync_next = (hcnt_reg >= H_VSYNC_HI_C);
        end else begin
            sync_next = (hcnt_reg >= H_SYNC_END_C);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hcnt_reg        <= '0;
            vcnt_reg        <= '0;
            row_base_reg    <= '0;
            vid_addr_reg    <= '0;
            font_addr_reg   <= '0;
            shift_reg       <= '0;
            luma_reg        <= 1'b0;
            sync_reg        <= 1'b1;
            frame_pulse_reg <= 1'b0;
        end else begin
            hcnt_reg        <= hcnt_next;
            vcnt_reg        <= vcnt_next;
            row_base_reg    <= row_base_next;
            vid_addr_reg    <= vid_addr_next;
            font_addr_reg   <= font_addr_next;
            shift_reg       <= shift_next;
            luma_reg        <= luma_next;
            sync_reg        <= sync_next;
            frame_pulse_reg <= frame_pulse_next;
        end
    end

    assign vbus.vid_addr    = vid_addr_reg;
    assign vbus.font_addr   = font_addr_reg;
    assign vbus.luma        = luma_reg;
    assign vbus.sync        = sync_reg;
    assign vbus.frame_pulse = frame_pulse_reg;

endmodule
